// File: rtl/wb_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue_if
// Description : Producer, retirement and hazard-lookup signals of the
//               writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_queue_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              mem_valid;
    logic              mem_ready;
    logic [4:0]        mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [4:0]        alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              stall;
    logic              reg_write;
    logic [4:0]        write_register;
    logic [DATA_W-1:0] write_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [4:0]        query_reg;
    logic              query_pending;

    // Producers, stall source and hazard logic
    modport master (
        output mem_valid, mem_reg, mem_data,
        output alu_valid, alu_reg, alu_data,
        output stall, query_reg,
        input  mem_ready, alu_ready,
        input  reg_write, write_register, write_data,
        input  count, full, empty, query_pending
    );

    // The queue itself
    modport slave (
        input  mem_valid, mem_reg, mem_data,
        input  alu_valid, alu_reg, alu_data,
        input  stall, query_reg,
        output mem_ready, alu_ready,
        output reg_write, write_register, write_data,
        output count, full, empty, query_pending
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : In-order writeback FIFO merging ALU and load results onto the
//               single register-file write port, with RAW pending lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  wire               clk,
    input  wire               rst,
    wb_write_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [4:0]        r_reg_mem  [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_reg_write;
    logic [4:0]        r_write_register;
    logic [DATA_W-1:0] r_write_data;

    logic              w_mem_ready;
    logic              w_alu_ready;
    logic              w_mem_acc;
    logic              w_alu_acc;
    logic              w_pop;
    logic [PTR_W-1:0]  w_alu_slot;
    logic [CNT_W-1:0]  w_mem_valid_ext;
    logic [CNT_W-1:0]  w_count_next;
    logic [DEPTH-1:0]  w_hit;

    // Space is judged on the current count only; a same-cycle pop frees nothing.
    assign w_mem_valid_ext = {{(CNT_W-1){1'b0}}, bus.mem_valid};
    assign w_mem_ready     = !rst && (r_count < c_depth);
    assign w_alu_ready     = !rst && ((r_count + w_mem_valid_ext) < c_depth);
    assign w_mem_acc       = bus.mem_valid && w_mem_ready;
    assign w_alu_acc       = bus.alu_valid && w_alu_ready;
    assign w_pop           = (r_count != '0) && !bus.stall;
    assign w_alu_slot      = r_wr_ptr + {{(PTR_W-1){1'b0}}, w_mem_acc};

    always_comb begin
        w_count_next = r_count;
        w_count_next = w_count_next + {{(CNT_W-1){1'b0}}, w_mem_acc};
        w_count_next = w_count_next + {{(CNT_W-1){1'b0}}, w_alu_acc};
        w_count_next = w_count_next - {{(CNT_W-1){1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else begin
            if (w_mem_acc) begin
                r_reg_mem[r_wr_ptr]  <= bus.mem_reg;
                r_data_mem[r_wr_ptr] <= bus.mem_data;
            end
            if (w_alu_acc) begin
                r_reg_mem[w_alu_slot]  <= bus.alu_reg;
                r_data_mem[w_alu_slot] <= bus.alu_data;
            end
            r_wr_ptr    <= r_wr_ptr + PTR_W'({1'b0, w_mem_acc} + {1'b0, w_alu_acc});
            r_count     <= w_count_next;
            // r0 entries still retire but never assert the write enable.
            r_reg_write <= w_pop && (r_reg_mem[r_rd_ptr] != 5'd0);
            if (w_pop) begin
                r_rd_ptr         <= r_rd_ptr + 1'b1;
                r_write_register <= r_reg_mem[r_rd_ptr];
                r_write_data     <= r_data_mem[r_rd_ptr];
            end
        end
    end

    // An entry is live when its distance from the head is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        logic [PTR_W-1:0] w_off;
        assign w_off    = PTR_W'(g) - r_rd_ptr;
        assign w_hit[g] = ({1'b0, w_off} < r_count) && (r_reg_mem[g] == bus.query_reg);
    end

    assign bus.query_pending  = (bus.query_reg != 5'd0) &&
                                ((|w_hit) || (r_reg_write && (r_write_register == bus.query_reg)));
    assign bus.mem_ready      = w_mem_ready;
    assign bus.alu_ready      = w_alu_ready;
    assign bus.reg_write      = r_reg_write;
    assign bus.write_register = r_write_register;
    assign bus.write_data     = r_write_data;
    assign bus.count          = r_count;
    assign bus.full           = (r_count == c_depth);
    assign bus.empty          = (r_count == '0);
endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Directed self-checking bench for wb_write_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    wb_write_queue_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    wb_write_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.stall = 1'b0; bus.query_reg = '0;

        // Reset state
        step(); step();
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_reg_write", 32'(bus.reg_write), 0);
        check("rst_wreg", 32'(bus.write_register), 0);
        check("rst_mem_ready", 32'(bus.mem_ready), 0);
        check("rst_alu_ready", 32'(bus.alu_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_mem_ready", 32'(bus.mem_ready), 1);

        // 1: single ALU write, one-cycle pulse after the following edge
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h11;
        step(); idle();
        check("t1_count", 32'(bus.count), 1);
        check("t1_early_we", 32'(bus.reg_write), 0);
        step();
        check("t1_we", 32'(bus.reg_write), 1);
        check("t1_wreg", 32'(bus.write_register), 3);
        check("t1_wdata", bus.write_data, 32'h11);
        check("t1_empty", 32'(bus.empty), 1);
        step();
        check("t1_we_drop", 32'(bus.reg_write), 0);

        // 2: simultaneous mem + ALU, mem retires first
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd5; bus.mem_data = 32'hAA;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd6; bus.alu_data = 32'hBB;
        #1;
        check("t2_alu_ready", 32'(bus.alu_ready), 1);
        step(); idle();
        check("t2_count", 32'(bus.count), 2);
        step();
        check("t2_we0", 32'(bus.reg_write), 1);
        check("t2_wreg0", 32'(bus.write_register), 5);
        check("t2_wdata0", bus.write_data, 32'hAA);
        step();
        check("t2_we1", 32'(bus.reg_write), 1);
        check("t2_wreg1", 32'(bus.write_register), 6);
        check("t2_wdata1", bus.write_data, 32'hBB);
        check("t2_count_end", 32'(bus.count), 0);
        step();

        // 3: fill under stall, then drain in order
        bus.stall = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd1;  bus.mem_data = 32'h101;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd2;  bus.alu_data = 32'h102;
        step();
        check("t3_count2", 32'(bus.count), 2);
        bus.mem_reg = 5'd9;  bus.mem_data = 32'h109;
        bus.alu_reg = 5'd10; bus.alu_data = 32'h10A;
        step();
        check("t3_count4", 32'(bus.count), 4);
        check("t3_full", 32'(bus.full), 1);
        check("t3_mem_ready", 32'(bus.mem_ready), 0);
        check("t3_alu_ready", 32'(bus.alu_ready), 0);
        step();
        check("t3_held_count", 32'(bus.count), 4);
        check("t3_held_we", 32'(bus.reg_write), 0);
        idle(); bus.stall = 1'b0;
        begin
            logic [4:0]  exp_reg  [4] = '{5'd1, 5'd2, 5'd9, 5'd10};
            logic [31:0] exp_data [4] = '{32'h101, 32'h102, 32'h109, 32'h10A};
            for (int i = 0; i < 4; i++) begin
                step();
                check("t3_we", 32'(bus.reg_write), 1);
                check("t3_wreg", 32'(bus.write_register), 32'(exp_reg[i]));
                check("t3_wdata", bus.write_data, exp_data[i]);
            end
        end
        check("t3_empty", 32'(bus.empty), 1);
        step();

        // 4: r0 entry retires without a write pulse
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd0; bus.mem_data = 32'hFF;
        step(); idle();
        check("t4_count1", 32'(bus.count), 1);
        step();
        check("t4_no_we", 32'(bus.reg_write), 0);
        check("t4_count0", 32'(bus.count), 0);

        // 5: hazard lookup
        bus.stall = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'h1;
        step(); idle();
        bus.query_reg = 5'd7; #1;
        check("t5_q7", 32'(bus.query_pending), 1);
        bus.query_reg = 5'd8; #1;
        check("t5_q8", 32'(bus.query_pending), 0);
        bus.query_reg = 5'd0; #1;
        check("t5_q0", 32'(bus.query_pending), 0);
        bus.query_reg = 5'd7; bus.stall = 1'b0;
        step();
        check("t5_retiring_we", 32'(bus.reg_write), 1);
        check("t5_q7_retiring", 32'(bus.query_pending), 1);
        step();
        check("t5_q7_after", 32'(bus.query_pending), 0);

        // 6: reset flushes queued entries
        bus.stall = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd11; bus.mem_data = 32'h211;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd12; bus.alu_data = 32'h212;
        step();
        bus.mem_valid = 1'b0; bus.alu_reg = 5'd13; bus.alu_data = 32'h213;
        step(); idle();
        check("t6_count3", 32'(bus.count), 3);
        bus.mem_valid = 1'b1; #1;
        check("t6_mem_ready_c3", 32'(bus.mem_ready), 1);
        check("t6_alu_ready_c3", 32'(bus.alu_ready), 0);
        bus.mem_valid = 1'b0; #1;
        check("t6_alu_ready_nomem", 32'(bus.alu_ready), 1);
        rst = 1'b1;
        step();
        check("t6_rst_count", 32'(bus.count), 0);
        check("t6_rst_we", 32'(bus.reg_write), 0);
        check("t6_rst_wreg", 32'(bus.write_register), 0);
        rst = 1'b0; bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_no_we", 32'(bus.reg_write), 0);
        end
        check("t6_empty", 32'(bus.empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
